// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_tx_arbiter                                            |
// | Description : Two-requester byte arbiter in front of one shared UART     |
// |               transmitter. Packets are never interleaved: the grant is   |
// |               locked until the byte flagged "last" has been sent.        |
// |               Optional macro UART_TX_ARB_ROUND_ROBIN_EN selects          |
// |               round-robin priority; undefined gives fixed priority       |
// |               with req0 winning ties.                                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_tx_arbiter #(
  // Cycles after tx_start before tx_busy is trusted; legal range 1..15.
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       busy
);

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_START = 3'd2,
    S_GAP   = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] ready_q, ready_d;
  logic       tx_start_q, tx_start_d;
  logic       busy_q, busy_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       last_q, last_d;
  logic       lock_q, lock_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
  // 0 = req0 preferred on a tie, 1 = req1 preferred.
  logic       pointer_q, pointer_d;
`endif

  logic       w_win1;
  logic       w_accept;
  logic [7:0] w_sel_data;
  logic       w_sel_last;

  // Winner selection for a new packet and the accept/mux of the granted requester.
  always_comb begin
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
    w_win1 = req1_valid && (!req0_valid || pointer_q);
`else
    w_win1 = req1_valid && !req0_valid;
`endif
    // The ready flops are only ever non-zero for the granted side, so an
    // accept is exactly a registered ready meeting its valid.
    w_accept   = (ready_q[0] && req0_valid) || (ready_q[1] && req1_valid);
    w_sel_data = grant_q[1] ? req1_data : req0_data;
    w_sel_last = grant_q[1] ? req1_last : req0_last;
  end

  // Next-state logic; every output is then registered from the next state.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    last_d    = last_q;
    lock_d    = lock_q;
    gap_cnt_d = gap_cnt_q;
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
    pointer_d = pointer_q;
`endif

    case (state_q)
      S_IDLE: begin
        // The grant may only change here, which keeps packets contiguous.
        if (!tx_busy && (req0_valid || req1_valid)) begin
          grant_d = w_win1 ? 2'b10 : 2'b01;
          state_d = S_GRANT;
        end
      end

      S_GRANT: begin
        if (w_accept) begin
          tx_data_d = w_sel_data;
          last_d    = w_sel_last;
          lock_d    = !w_sel_last;
          state_d   = S_START;
        end else if (!lock_q) begin
          // Requester withdrew before its first byte: release the grant.
          grant_d = 2'b00;
          state_d = S_IDLE;
        end
      end

      S_START: begin
        gap_cnt_d = GAP_LOAD;
        state_d   = S_GAP;
      end

      S_GAP: begin
        // Transmitter busy is not yet meaningful; just count the gap down.
        if (gap_cnt_q <= 4'd1) begin
          gap_cnt_d = 4'd0;
          state_d   = S_WAIT;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end

      S_WAIT: begin
        if (!tx_busy) begin
          if (!last_q) begin
            state_d = S_GRANT;
          end else begin
            grant_d = 2'b00;
            lock_d  = 1'b0;
            state_d = S_IDLE;
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
            // Favour whichever requester did not just finish a packet.
            pointer_d = grant_q[0];
`endif
          end
        end
      end

      default: begin
        grant_d = 2'b00;
        lock_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    ready_d    = (state_d == S_GRANT) ? grant_d : 2'b00;
    tx_start_d = (state_d == S_START);
    busy_d     = (state_d != S_IDLE);
  end

  // State and registered outputs; reset takes effect asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      grant_q    <= 2'b00;
      ready_q    <= 2'b00;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      last_q     <= 1'b0;
      lock_q     <= 1'b0;
      gap_cnt_q  <= 4'd0;
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
      pointer_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ready_q    <= ready_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      tx_data_q  <= tx_data_d;
      last_q     <= last_d;
      lock_q     <= lock_d;
      gap_cnt_q  <= gap_cnt_d;
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
      pointer_q  <= pointer_d;
`endif
    end
  end

  assign req0_ready = ready_q[0];
  assign req1_ready = ready_q[1];
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign grant      = grant_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_tx_arbiter                                         |
// | Description : Self-checking bench for uart_tx_arbiter: queued requester  |
// |               drivers, a busy-model transmitter and a scoreboard of      |
// |               expected {byte, grant} per tx_start.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

  localparam int BUSY_LEN = 10;

  typedef struct { logic [7:0] data; logic last; int idle; } beat_t;
  typedef struct { logic [7:0] data; logic [1:0] grant; } exp_t;
  typedef struct {
    logic v0; logic [7:0] d0; logic v1; logic [7:0] d1;
    exp_t e0; exp_t e1; int n;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_last = 1'b0, req1_last = 1'b0;
  logic       req0_ready, req1_ready, tx_start, busy;
  logic [7:0] tx_data;
  logic [1:0] grant;
  logic       tx_busy;
  logic       model_busy = 1'b0, force_busy = 1'b0;

  int total = 0;
  int bad = 0;

  beat_t q0[$], q1[$];
  exp_t  sb[$];
  beat_t cur0, cur1;
  logic  have0 = 1'b0, have1 = 1'b0, pend0 = 1'b0, pend1 = 1'b0;
  int    busy_left = 0;
  logic  start_prev = 1'b0, mon_prev = 1'b0;

  assign tx_busy = model_busy || force_busy;

  uart_tx_arbiter #(.GAP_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester 0 driver: presents queue head, honours idle gaps, pops on accept.
  initial forever begin
    @(negedge clk);
    if (pend0) begin have0 = 1'b0; pend0 = 1'b0; end
    if (!have0 && q0.size() > 0) begin cur0 = q0.pop_front(); have0 = 1'b1; end
    if (have0 && cur0.idle > 0) begin
      cur0.idle--; req0_valid = 1'b0;
    end else if (have0) begin
      req0_valid = 1'b1; req0_data = cur0.data; req0_last = cur0.last;
    end else begin
      req0_valid = 1'b0;
    end
    pend0 = req0_valid && req0_ready && reset_n;
  end

  // Requester 1 driver.
  initial forever begin
    @(negedge clk);
    if (pend1) begin have1 = 1'b0; pend1 = 1'b0; end
    if (!have1 && q1.size() > 0) begin cur1 = q1.pop_front(); have1 = 1'b1; end
    if (have1 && cur1.idle > 0) begin
      cur1.idle--; req1_valid = 1'b0;
    end else if (have1) begin
      req1_valid = 1'b1; req1_data = cur1.data; req1_last = cur1.last;
    end else begin
      req1_valid = 1'b0;
    end
    pend1 = req1_valid && req1_ready && reset_n;
  end

  // Transmitter model: busy rises the cycle after tx_start and lasts BUSY_LEN cycles.
  initial forever begin
    @(negedge clk);
    if (start_prev) busy_left = BUSY_LEN;
    start_prev = tx_start;
    model_busy = (busy_left > 0);
    if (busy_left > 0) busy_left--;
  end

  // Scoreboard monitor: every tx_start must match the next expected byte/grant.
  initial forever begin
    @(negedge clk);
    if (tx_start) begin
      check("tx_start_one_cycle", {31'd0, mon_prev}, 32'd0);
      check("tx_start_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("tx_data", {24'd0, tx_data}, {24'd0, e.data});
        check("tx_grant", {30'd0, grant}, {30'd0, e.grant});
      end
    end
    mon_prev = tx_start;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic flush();
    q0.delete(); q1.delete(); sb.delete();
    have0 = 1'b0; have1 = 1'b0; pend0 = 1'b0; pend1 = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    flush();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk); #1;
      if (q0.size() == 0 && q1.size() == 0 && !have0 && !have1 &&
          sb.size() == 0 && !busy && !tx_busy) break;
      n++;
    end
    check(name, {31'd0, n < budget}, 32'd1);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [1:0] g);
    exp_t e;
    e.data = d; e.grant = g;
    sb.push_back(e);
  endtask

  task automatic push_beat(input int r, input logic [7:0] d, input logic l, input int idle);
    beat_t b;
    b.data = d; b.last = l; b.idle = idle;
    if (r == 0) q0.push_back(b); else q1.push_back(b);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{1'b1, 8'h3C, 1'b0, 8'h00, '{8'h3C, 2'b01}, '{8'h00, 2'b00}, 1};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 8'hC3, '{8'hC3, 2'b10}, '{8'h00, 2'b00}, 1};
    vecs[2] = '{1'b1, 8'h11, 1'b1, 8'h22, '{8'h11, 2'b01}, '{8'h22, 2'b10}, 2};
    vecs[3] = '{1'b1, 8'h00, 1'b1, 8'hFF, '{8'h00, 2'b01}, '{8'hFF, 2'b10}, 2};
    vecs[4] = '{1'b1, 8'hFF, 1'b0, 8'h00, '{8'hFF, 2'b01}, '{8'h00, 2'b00}, 1};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Table of single-byte arbitration cases, each from a fresh reset.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      push_exp(vecs[i].e0.data, vecs[i].e0.grant);
      if (vecs[i].n == 2) push_exp(vecs[i].e1.data, vecs[i].e1.grant);
      if (vecs[i].v0) push_beat(0, vecs[i].d0, 1'b1, 0);
      if (vecs[i].v1) push_beat(1, vecs[i].d1, 1'b1, 0);
      wait_idle("vec_done", 200);
    end

    // Latency: valid at edge n -> ready in n+1 -> tx_start in n+2.
    do_reset();
    push_exp(8'h5A, 2'b10);
    push_beat(1, 8'h5A, 1'b1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (req1_valid) break;
    end
    check("lat_valid_seen", {31'd0, req1_valid}, 32'd1);
    check("lat_ready_n", {31'd0, req1_ready}, 32'd0);
    @(negedge clk); #1;
    check("lat_ready_n1", {31'd0, req1_ready}, 32'd1);
    check("lat_grant_n1", {30'd0, grant}, 32'd2);
    @(negedge clk); #1;
    check("lat_start_n2", {31'd0, tx_start}, 32'd1);
    check("lat_ready_off", {31'd0, req1_ready}, 32'd0);
    wait_idle("lat_done", 200);

    // Single byte 0xA5 from req0, then back to idle once busy falls.
    do_reset();
    push_exp(8'hA5, 2'b01);
    push_beat(0, 8'hA5, 1'b1, 0);
    wait_idle("a5_done", 200);
    check("a5_grant_idle", {30'd0, grant}, 32'd0);
    check("a5_tx_data_hold", {24'd0, tx_data}, 32'hA5);

    // Locked 3-byte packet from req0 with req1 waiting.
    do_reset();
    push_exp(8'h01, 2'b01); push_exp(8'h02, 2'b01); push_exp(8'h03, 2'b01);
    push_exp(8'h55, 2'b10);
    push_beat(0, 8'h01, 1'b0, 0); push_beat(0, 8'h02, 1'b0, 0); push_beat(0, 8'h03, 1'b1, 0);
    push_beat(1, 8'h55, 1'b1, 0);
    wait_idle("pkt_done", 400);

    // Both requesters continuously offering single-byte packets.
    do_reset();
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 4; i++) begin
      push_exp(8'hA0 + 8'(i), 2'b01);
      push_exp(8'hB0 + 8'(i), 2'b10);
    end
`else
    for (int i = 0; i < 4; i++) push_exp(8'hA0 + 8'(i), 2'b01);
    for (int i = 0; i < 4; i++) push_exp(8'hB0 + 8'(i), 2'b10);
`endif
    for (int i = 0; i < 4; i++) begin
      push_beat(0, 8'hA0 + 8'(i), 1'b1, 0);
      push_beat(1, 8'hB0 + 8'(i), 1'b1, 0);
    end
    wait_idle("arb_done", 800);

    // External busy holds off req1 until it drops.
    do_reset();
    @(negedge clk);
    force_busy = 1'b1;
    push_exp(8'hC7, 2'b10);
    push_beat(1, 8'hC7, 1'b1, 0);
    begin
      logic seen;
      seen = 1'b0;
      repeat (6) begin @(negedge clk); #1; if (req1_ready) seen = 1'b1; end
      check("busy_holdoff", {31'd0, seen}, 32'd0);
    end
    @(negedge clk);
    force_busy = 1'b0;
    #1 check("busy_ready_same", {31'd0, req1_ready}, 32'd0);
    @(negedge clk); #1;
    check("busy_ready_next", {31'd0, req1_ready}, 32'd1);
    wait_idle("busy_done", 200);

    // Asynchronous reset during GAP of a locked packet.
    do_reset();
    push_exp(8'h10, 2'b01);
    push_beat(0, 8'h10, 1'b0, 0); push_beat(0, 8'h20, 1'b0, 0); push_beat(0, 8'h30, 1'b1, 0);
    begin
      int n;
      n = 0;
      while (n < 50) begin @(negedge clk); #1; if (tx_start) break; n++; end
      check("ar_start_seen", {31'd0, n < 50}, 32'd1);
    end
    @(negedge clk); #2;
    check("ar_pre_grant", {30'd0, grant}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("ar_grant", {30'd0, grant}, 32'd0);
    check("ar_busy", {31'd0, busy}, 32'd0);
    check("ar_tx_data", {24'd0, tx_data}, 32'd0);
    check("ar_ready_start", {29'd0, tx_start, req1_ready, req0_ready}, 32'd0);
    flush();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    push_exp(8'h77, 2'b10);
    push_beat(1, 8'h77, 1'b1, 0);
    wait_idle("ar_after", 300);

    // Requester stalls mid-packet: grant held, no start, req1 kept out.
    do_reset();
    push_exp(8'h41, 2'b01); push_exp(8'h42, 2'b01); push_exp(8'h99, 2'b10);
    push_beat(0, 8'h41, 1'b0, 0); push_beat(0, 8'h42, 1'b1, 25);
    push_beat(1, 8'h99, 1'b1, 0);
    begin
      int n;
      n = 0;
      while (n < 10) begin @(negedge clk); #1; if (tx_start) break; n++; end
      n = 0;
      while (n < 40) begin @(negedge clk); #1; if (req0_ready) break; n++; end
      check("stall_regrant", {31'd0, n < 40}, 32'd1);
      repeat (5) begin
        @(negedge clk); #1;
        check("stall_grant", {29'd0, tx_start, grant}, 32'd1);
      end
    end
    wait_idle("stall_done", 400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 2: cycles after tx_start before tx_busy is sampled, covering the transmitter's busy-assert latency; legal range 1..15.
REQ-002 SHALL have port clk  input  1  single clock, all flops on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid, req1_valid  input  1  requester has a byte offered.
REQ-005 SHALL have ports req0_data, req1_data  input  8  offered byte.
REQ-006 SHALL have ports req0_last, req1_last  input  1  offered byte ends the requester's packet.
REQ-007 SHALL have ports req0_ready, req1_ready  output  1  byte accepted when valid and ready are both high on the same edge.
REQ-008 SHALL have port tx_start  output  1  one-cycle start pulse to the shared UART transmitter.
REQ-009 SHALL have port tx_data  output  8  registered byte presented to the transmitter.
REQ-010 SHALL have port tx_busy  input  1  transmitter busy flag.
REQ-011 SHALL have port grant  output  2  one-hot owner of the transmitter, 00 when idle.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, GRANT, START, GAP, WAIT.
REQ-014 IDLE: when tx_busy=0 and any reqN_valid=1, select a winner (REQ-021), set grant, go to GRANT; if tx_busy=1, stay in IDLE.
REQ-015 GRANT: assert ready of the granted requester only; when its valid=1, latch data into tx_data and last into an internal flag, go to START.
REQ-016 GRANT with granted valid=0: stay if mid-packet (lock set), else return to IDLE and clear grant.
REQ-017 START: tx_start=1 for exactly one cycle, load the gap counter with GAP_CYCLES, go to GAP.
REQ-018 GAP: decrement the counter; at 0 go to WAIT; tx_busy is ignored in GAP.
REQ-019 WAIT: stay while tx_busy=1; on tx_busy=0 go to GRANT with the same grant if the latched last=0 (packet lock), else go to IDLE, clear grant, and update the priority pointer.
REQ-020 Latency: valid seen in IDLE at edge n gives ready=1 in cycle n+1 and tx_start=1 in cycle n+2, assuming valid is held.
REQ-021 With both valid in IDLE, the winner is the requester named by the priority pointer; with one valid, that requester wins regardless of pointer.
REQ-022 A packet SHALL never be interleaved with the other requester's bytes; grant changes only in IDLE.
REQ-023 reqN_ready, tx_start, grant, and busy SHALL be decoded from flops only, with no combinational path from any input.
REQ-024 tx_data SHALL hold its value from START until the next accept.

Reset
REQ-025 Asserting reset_n=0 at any time, including mid-packet, SHALL immediately force state=IDLE, grant=00, tx_start=0, req0_ready=0, req1_ready=0, busy=0, tx_data=8'h00, lock cleared, pointer=req0, and gap counter=0.
REQ-026 After release, the first acceptance SHALL occur no earlier than the second rising edge.

Configuration
REQ-027 Macro UART_TX_ARB_ROUND_ROBIN_EN defined: the pointer toggles to the other requester after each completed packet (REQ-019).
REQ-028 Macro UART_TX_ARB_ROUND_ROBIN_EN undefined: fixed priority, req0 always wins ties, pointer logic absent.

Verification
REQ-029 req0 sends 0xA5 with last=1 and tx_busy modelled high 1 cycle after start for 10 cycles -> one tx_start, tx_data=0xA5, grant=01, and return to IDLE after busy falls.
REQ-030 req0 3-byte packet 0x01,0x02,0x03 (last on third) while req1_valid is held high with 0x55 -> tx sequence 01,02,03,55 and grant never 10 before the third byte completes.
REQ-031 Both requesters valid with single-byte packets, repeated 4 times, round-robin enabled -> grant order 01,10,01,10; macro undefined -> 01,01,01,01.
REQ-032 tx_busy=1 externally while req1_valid=1 -> req1_ready stays 0 until tx_busy=0, then ready follows 1 cycle later.
REQ-033 reset_n pulsed low during GAP of a locked packet -> all outputs reach reset values asynchronously, and a later req1 byte is granted normally.
REQ-034 Requester drops valid in GRANT mid-packet for 5 cycles -> grant is held and no tx_start occurs, then resumes when valid returns.
